// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalizer that turns a raw sign/exponent/25-bit magnitude
// into a packed IEEE-754 single, with overflow/underflow flags, over a small FSM.
module fp_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [24:0] mant_in,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        ovf,
    output logic        unf
);
    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, PACK} state_t;
    state_t             state, state_n;
    logic               s;
    logic signed [9:0]  e, e_n;
    logic [24:0]        m, m_n;
    logic               zero, zero_n, ovf_p, ovf_p_n, unf_p, unf_p_n;
    logic [31:0]        res_n;
    assign done = (state == PACK);
    assign busy = (state != IDLE);
    always_comb begin
        state_n = state;
        e_n     = e;
        m_n     = m;
        zero_n  = zero;
        ovf_p_n = ovf_p;
        unf_p_n = unf_p;
        case (state)
            IDLE: if (start) begin
                state_n = CHECK;
                e_n     = {2'b00, exp_in};
                m_n     = mant_in;
                zero_n  = 1'b0;
                ovf_p_n = 1'b0;
                unf_p_n = 1'b0;
            end
            CHECK: begin
                state_n = PACK;
                if (m == 25'd0) zero_n = 1'b1;
                else if (e == 10'sd255) ovf_p_n = 1'b1;
                else if (m[24]) begin
                    m_n     = m >> 1;
                    e_n     = e + 10'sd1;
                    ovf_p_n = (e >= 10'sd254);
                end
                else if (!m[23]) state_n = SHIFT;
            end
            SHIFT: if (e <= 10'sd1) begin
                unf_p_n = 1'b1;
                state_n = PACK;
            end else begin
                m_n     = m << 1;
                e_n     = e - 10'sd1;
                state_n = m[22] ? PACK : SHIFT;
            end
            default: state_n = IDLE;
        endcase
        // result is loaded on the edge into PACK so it is valid while done is high
        res_n = ovf_p_n ? {s, 8'hFF, 23'h0} :
                (unf_p_n | zero_n) ? {s, 31'h0} : {s, e_n[7:0], m_n[22:0]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            s      <= 1'b0;
            e      <= '0;
            m      <= '0;
            zero   <= 1'b0;
            ovf_p  <= 1'b0;
            unf_p  <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            state <= state_n;
            e     <= e_n;
            m     <= m_n;
            zero  <= zero_n;
            ovf_p <= ovf_p_n;
            unf_p <= unf_p_n;
            if (state == IDLE && start) begin
                s   <= sign_in;
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (state != PACK && state_n == PACK) begin
                result <= res_n;
                ovf    <= ovf_p_n;
                unf    <= unf_p_n & ~ovf_p_n;
            end
        end
    end
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed vector table plus hand sequences for reset abort
// and start held high across several operations.
module tb_fp_normalizer;
    logic        clk, rst, start, sign_in;
    logic [7:0]  exp_in;
    logic [24:0] mant_in;
    logic [31:0] result;
    logic        done, busy, ovf, unf;
    int          n_chk = 0, n_fail = 0;

    fp_normalizer dut (
        .clk(clk), .rst(rst), .start(start), .sign_in(sign_in), .exp_in(exp_in),
        .mant_in(mant_in), .result(result), .done(done), .busy(busy), .ovf(ovf), .unf(unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one start and counts busy cycles up to and including the done cycle.
    task automatic run(input vec_t v, output int lat, output logic flags_at_capture);
        @(posedge clk);
        #1;
        sign_in = v.sign;
        exp_in  = v.exp;
        mant_in = v.mant;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flags_at_capture = ovf | unf;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t vecs[12];
    int   lat, dones, accepts;
    logic fl;

    initial begin
        vecs[0]  = '{1'b0, 8'd127, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 8'd127, 25'h1000001, 32'h40000000, 1'b0, 1'b0, 2};
        vecs[2]  = '{1'b1, 8'd127, 25'h0200000, 32'hBE800000, 1'b0, 1'b0, 4};
        vecs[3]  = '{1'b0, 8'd254, 25'h1000000, 32'h7F800000, 1'b1, 1'b0, 2};
        vecs[4]  = '{1'b0, 8'd10,  25'h0000001, 32'h00000000, 1'b0, 1'b1, -1};
        vecs[5]  = '{1'b1, 8'd77,  25'h0000000, 32'h80000000, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b0, 8'd255, 25'h0800000, 32'h7F800000, 1'b1, 1'b0, 2};
        vecs[7]  = '{1'b1, 8'h80,  25'h0FFFFFF, 32'hC07FFFFF, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b0, 8'd2,   25'h0400000, 32'h00800000, 1'b0, 1'b0, 3};
        vecs[9]  = '{1'b0, 8'd2,   25'h0200000, 32'h00000000, 1'b0, 1'b1, 4};
        vecs[10] = '{1'b0, 8'd200, 25'h0000001, 32'h58800000, 1'b0, 1'b0, 25};
        vecs[11] = '{1'b0, 8'd1,   25'h0400000, 32'h00000000, 1'b0, 1'b1, 3};

        rst = 1'b1; start = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0;
        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {28'h0, done, busy, ovf, unf}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run(vecs[i], lat, fl);
            chk($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_ovf_unf", i), {30'h0, ovf, unf}, {30'h0, vecs[i].ovf, vecs[i].unf});
            chk($sformatf("v%0d_flags_cleared", i), {31'h0, fl}, 32'h0);
            if (vecs[i].lat >= 0) chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {30'h0, done, busy}, 32'h0);
            chk($sformatf("v%0d_hold", i), result, vecs[i].res);
        end

        // reset in the middle of a long SHIFT run
        @(posedge clk);
        #1;
        sign_in = 1'b0; exp_in = 8'd200; mant_in = 25'h0000001; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("rst_no_done", dones, 0);
        run(vecs[2], lat, fl);
        chk("post_rst_result", result, 32'hBE800000);
        chk("post_rst_latency", lat, 4);

        // start held high: each acceptance gives exactly one done
        @(posedge clk);
        #1;
        chk("held_idle", {31'h0, busy}, 32'h0);
        sign_in = 1'b0; exp_in = 8'd127; mant_in = 25'h0800000; start = 1'b1;
        dones = 0;
        accepts = 0;
        repeat (9) begin
            if (!busy) accepts++;
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("held_dones", dones, 3);
        chk("held_dones_vs_accepts", dones, accepts);
        chk("held_result", result, 32'h3F800000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 The block SHALL provide these ports:
  clk  in  1  clock; all state changes on the rising edge
  rst  in  1  reset, asynchronous, active-high
  start  in  1  request; sampled only in IDLE
  sign_in  in  1  sign of the raw adder result
  exp_in  in  8  biased exponent of the raw result
  mant_in  in  25  raw magnitude; bit24 = carry-out, bit23 = hidden-bit position
  result  out  32  packed IEEE-754 single (sign, exp[7:0], frac[22:0]), registered
  done  out  1  one-cycle pulse; result valid
  busy  out  1  high in every state except IDLE
  ovf  out  1  overflow flag, registered with result
  unf  out  1  underflow flag, registered with result
REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The FSM SHALL have four states: IDLE, CHECK, SHIFT and PACK.
REQ-004 In IDLE with start=1, the block SHALL capture sign_in, exp_in and mant_in into internal registers S, E (10-bit signed) and M (25-bit), then go to CHECK.
REQ-005 In IDLE with start=0, the block SHALL stay in IDLE with internal registers and outputs held.
REQ-006 CHECK, M==0: the block SHALL set the zero flag and go to PACK.
REQ-007 CHECK, exp_in==255 captured: the block SHALL set ovf-pending and go to PACK.
REQ-008 CHECK, M[24]=1: the block SHALL apply M=M>>1 (LSB truncated) and E=E+1, then go to PACK.
  - If the resulting E >= 255, it SHALL also set ovf-pending.
REQ-009 CHECK, M[24:23]=01: the block SHALL go to PACK unchanged.
REQ-010 CHECK, otherwise: the block SHALL go to SHIFT.
REQ-011 SHIFT, if E<=1: the block SHALL set unf-pending and go to PACK without shifting.
REQ-012 SHIFT, if E>1: the block SHALL apply M=M<<1 and E=E-1.
  - It SHALL go to PACK once the shifted M[23]=1, else stay in SHIFT.
  - Shifting SHALL take at most 23 cycles.
REQ-013 PACK SHALL register the result by priority:
  - ovf-pending: {S, 8'hFF, 23'h0}, with ovf=1.
  - else unf-pending or zero: {S, 31'h0}, with unf=1 only for underflow.
  - else {S, E[7:0], M[22:0]}.
REQ-014 In PACK, done SHALL be 1 for exactly that cycle, and the next state SHALL be IDLE.
REQ-015 result, ovf and unf SHALL hold their values until the next PACK; ovf and unf SHALL be cleared on capture in IDLE.
REQ-016 Latency from the sampling edge of start to done high SHALL be 2 cycles plus the number of SHIFT cycles.
REQ-017 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 done and busy SHALL be decoded from state only (Moore outputs).

Reset
REQ-020 rst=1 SHALL immediately force IDLE and clear S, E, M, all pending flags, result, done, ovf and unf to 0, and set busy to 0.
REQ-021 rst asserted mid-operation (CHECK, SHIFT or PACK) SHALL abort without a done pulse.
  - The first start after rst deasserts SHALL be processed normally.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  - sign=0, exp=127, mant=0x0800000 -> result=0x3F800000, done 2 cycles after start, ovf=unf=0.
  - sign=0, exp=127, mant=0x1000001 (carry) -> result=0x40000000 (LSB truncated), latency 2.
  - sign=1, exp=127, mant=0x0200000 -> 2 SHIFT cycles, result=0xBE800000, latency 4.
  - sign=0, exp=254, mant=0x1000000 -> result=0x7F800000, ovf=1.
  - sign=0, exp=10, mant=0x0000001 -> 9 SHIFT cycles, then result=0x00000000, unf=1.
  - sign=1, mant=0 -> result=0x80000000, unf=0.
  - rst pulsed during SHIFT -> busy=0 and result=0 at once, no done.
  - start held high through an operation -> exactly one done per accepted start.
